// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: request -> wait -> hold loop, three cycles per instruction with zero-wait memory.
// Holds inst/pc until the decoder consumes them; a fetch fault or a misaligned redirect parks it in S_ERR until reset.
module ysyx_22050039_ifu #(
  parameter int                XLEN     = 64,
  parameter int                INST_LEN = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  input  logic                imem_resp_err,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                pc_wen,
  input  logic [XLEN-1:0]     dnpc,
  output logic                fetch_err,
  output logic [63:0]         inst_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [63:0]         cnt_q, cnt_d;
  // Keeps the request off while reset is held and lets it rise on the first edge after release.
  logic                live_q, live_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    live_d  = 1'b1;
    case (state_q)
      S_REQ: begin
        if (live_q && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = S_ERR;
          end else begin
            inst_d  = imem_resp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          cnt_d = cnt_q + 64'd1;
          if (pc_wen) begin
            pc_d    = dnpc;
            state_d = (dnpc[1:0] != 2'b00) ? S_ERR : S_REQ;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // All handshake outputs decode registered state only.
  assign imem_req_valid = (state_q == S_REQ) && live_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign fetch_err      = (state_q == S_ERR);
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign inst_cnt       = cnt_q;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Bench for ysyx_22050039_ifu: transaction-level model of fetch/consume/fault plus directed literal scenarios.
module tb_ysyx_22050039_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        pc_wen = 1'b0;
  logic [63:0] dnpc = '0;
  logic        fetch_err;
  logic [63:0] inst_cnt;

  ysyx_22050039_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc_wen(pc_wen), .dnpc(dnpc), .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Stimulus knobs for the next cycle.
  logic        d_rst = 1'b1;
  logic        d_req_ready, d_inst_ready, d_pc_wen, d_err, d_spur, d_fixed_en;
  logic [63:0] d_dnpc;
  logic [31:0] d_fixed_val;
  int          d_lat;

  // Abstract model: what has been requested, returned, consumed.
  logic [63:0] m_pc, m_cnt;
  logic [31:0] m_inst;
  logic        m_err, m_out, m_have, m_started;
  int          lat_cnt;
  logic        err_pend;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (d_fixed_en) return d_fixed_val;
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_cnt = '0; m_inst = '0;
    m_err = 1'b0; m_out = 1'b0; m_have = 1'b0; m_started = 1'b0;
    lat_cnt = 0; err_pend = 1'b0;
  endtask

  task automatic cycle();
    logic exp_req;
    @(negedge clk);
    exp_req = m_started && !m_out && !m_have && !m_err;
    chk("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_req});
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, m_have});
    chk("req_addr", imem_req_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst", {32'd0, inst}, {32'd0, m_inst});
    chk("inst_cnt", inst_cnt, m_cnt);
    chk("fetch_err", {63'd0, fetch_err}, {63'd0, m_err});
    chk("excl", {63'd0, imem_req_valid & inst_valid}, 64'd0);
    imem_req_ready = d_req_ready;
    inst_ready     = d_inst_ready;
    pc_wen         = d_pc_wen;
    dnpc           = d_dnpc;
    if (m_out && lat_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(m_pc);
      imem_resp_err   = err_pend;
    end else if (m_out) begin
      lat_cnt--;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom);
    end else begin
      imem_resp_valid = d_spur;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom);
    end
    rst = d_rst;
    if (!d_rst) begin
      model_reset();
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (exp_req && d_req_ready) begin
      m_out = 1'b1; lat_cnt = d_lat; err_pend = d_err;
    end else if (m_out && imem_resp_valid) begin
      m_out = 1'b0;
      if (imem_resp_err) m_err = 1'b1;
      else begin m_have = 1'b1; m_inst = imem_resp_data; end
    end else if (m_have && d_inst_ready) begin
      m_have = 1'b0;
      m_cnt  = m_cnt + 64'd1;
      m_pc   = d_pc_wen ? d_dnpc : m_pc + 64'd4;
      if (d_pc_wen && d_dnpc[1:0] != 2'b00) m_err = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_pc", pc, 64'h0000_0000_8000_0000);
    chk("rst_cnt", inst_cnt, 64'd0);
    chk("rst_err", {63'd0, fetch_err}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    d_rst = 1'b0;
    cycle();
    d_rst = 1'b1;
    cycle();
  endtask

  task automatic directed_defaults();
    d_req_ready = 1'b1; d_inst_ready = 1'b1; d_pc_wen = 1'b0; d_dnpc = '0;
    d_err = 1'b0; d_spur = 1'b0; d_lat = 0;
    d_fixed_en = 1'b1; d_fixed_val = 32'h0000_0413;
  endtask

  initial begin
    directed_defaults();
    model_reset();

    // Zero-wait fetch loop.
    do_reset();
    cycle();
    chk("l36_req", {63'd0, imem_req_valid}, 64'd1);
    chk("l36_addr", imem_req_addr, 64'h8000_0000);
    cycle();
    chk("l36_wait_iv", {63'd0, inst_valid}, 64'd0);
    cycle();
    chk("l36_iv", {63'd0, inst_valid}, 64'd1);
    chk("l36_inst", {32'd0, inst}, 64'h413);
    cycle();
    chk("l36_addr2", imem_req_addr, 64'h8000_0004);
    chk("l36_cnt", inst_cnt, 64'd1);

    // Request stall, hold stall with redirect, misaligned redirect.
    do_reset();
    d_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("l37_req", {63'd0, imem_req_valid}, 64'd1);
      chk("l37_addr", imem_req_addr, 64'h8000_0000);
    end
    d_req_ready = 1'b1; d_inst_ready = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("l38_iv", {63'd0, inst_valid}, 64'd1);
      chk("l38_inst", {32'd0, inst}, 64'h413);
    end
    d_inst_ready = 1'b1; d_pc_wen = 1'b1; d_dnpc = 64'h8000_0100;
    cycle();
    d_pc_wen = 1'b0;
    cycle();
    chk("l38_addr", imem_req_addr, 64'h8000_0100);
    chk("l38_cnt", inst_cnt, 64'd1);
    cycle();
    d_pc_wen = 1'b1; d_dnpc = 64'h8000_0102;
    cycle();
    d_pc_wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("l39_err", {63'd0, fetch_err}, 64'd1);
      chk("l39_req", {63'd0, imem_req_valid}, 64'd0);
      chk("l39_pc", pc, 64'h8000_0102);
    end

    // Fetch fault, then reset clears it.
    do_reset();
    d_err = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("l40_iv", {63'd0, inst_valid}, 64'd0);
    end
    chk("l40_err", {63'd0, fetch_err}, 64'd1);
    d_err = 1'b0;
    do_reset();

    // Reset during wait, stale response afterwards.
    d_lat = 3;
    cycle();
    cycle();
    d_spur = 1'b1; d_req_ready = 1'b0;
    do_reset();
    cycle();
    chk("l41_req", {63'd0, imem_req_valid}, 64'd1);
    chk("l41_addr", imem_req_addr, 64'h8000_0000);
    chk("l41_iv", {63'd0, inst_valid}, 64'd0);

    // Randomized segments.
    d_fixed_en = 1'b0;
    for (int seg = 0; seg < 12; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        int r;
        d_req_ready  = ($urandom % 3) != 0;
        d_inst_ready = ($urandom % 3) != 0;
        d_pc_wen     = ($urandom % 4) == 0;
        r = int'($urandom % 40);
        if (r == 0)      d_dnpc = m_pc + 64'($urandom_range(1, 3));
        else if (r == 1) d_dnpc = 64'hFFFF_FFFF_FFFF_FFFC;
        else             d_dnpc = m_pc + 64'({$urandom_range(0, 63), 2'b00}) - 64'd128;
        d_lat  = int'($urandom % 4);
        d_err  = ($urandom % 60) == 0;
        d_spur = 1'($urandom);
        d_rst  = ($urandom % 250) != 0;
        cycle();
      end
      d_rst = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_ifu.md
YSYX_22050039_IFU -- requirements
Module: ysyx_22050039_IFU

Interface
REQ-001 Parameter XLEN, default 64, datapath and PC width.
REQ-002 Parameter INST_LEN, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address.
REQ-004 Clock and reset SHALL be a single clock `clk` and a reset `rst` that is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 imem_req_valid  out  1  fetch request valid.
REQ-008 imem_req_ready  in  1  memory accepts request.
REQ-009 imem_req_addr  out  XLEN  fetch address, always equals pc.
REQ-010 imem_resp_valid  in  1  response data valid, one-cycle pulse.
REQ-011 imem_resp_data  in  INST_LEN  fetched instruction.
REQ-012 imem_resp_err  in  1  access fault, qualified by imem_resp_valid.
REQ-013 inst  out  INST_LEN  registered instruction to decoder.
REQ-014 pc  out  XLEN  address of inst.
REQ-015 inst_valid  out  1  inst/pc valid for decoder.
REQ-016 inst_ready  in  1  decoder/execute consumes inst this cycle.
REQ-017 pc_wen  in  1  redirect request from execute, same cycle as consume.
REQ-018 dnpc  in  XLEN  redirect target.
REQ-019 fetch_err  out  1  sticky fetch fault flag.
REQ-020 inst_cnt  out  64  retired (consumed) instruction count.

Function
REQ-021 FSM states SHALL be S_REQ, S_WAIT, S_HOLD, S_ERR, one-hot or binary encoded.
REQ-022 S_REQ: imem_req_valid=1; on imem_req_ready go S_WAIT, else stay.
REQ-023 S_WAIT: imem_req_valid=0; on imem_resp_valid with imem_resp_err=0, latch imem_resp_data into inst, go S_HOLD.
REQ-024 S_WAIT: on imem_resp_valid with imem_resp_err=1, go S_ERR, inst unchanged.
REQ-025 S_HOLD: inst_valid=1; inst and pc SHALL stay stable until inst_ready=1.
REQ-026 S_HOLD with inst_ready=1: go S_REQ; pc <= pc_wen ? dnpc : pc+4 (XLEN-bit wrap, no carry out); inst_cnt += 1 (wraps at 2^64).
REQ-027 S_HOLD with inst_ready=1, pc_wen=1 and dnpc[1:0]!=0: go S_ERR, pc <= dnpc, inst_cnt += 1.
REQ-028 pc_wen SHALL be ignored unless inst_valid and inst_ready are both 1.
REQ-029 imem_resp_valid outside S_WAIT SHALL be ignored.
REQ-030 S_ERR: terminal until reset; fetch_err=1, imem_req_valid=0, inst_valid=0.
REQ-031 Minimum fetch loop: S_REQ->S_WAIT->S_HOLD, 3 cycles per instruction with zero-wait memory and inst_ready tied high.
REQ-032 inst_valid and imem_req_valid SHALL be mutually exclusive and driven from state only (no input-to-output combinational path).

Reset
REQ-033 On rst=0, asynchronously: state=S_REQ, pc=RESET_PC, inst=0, inst_cnt=0, fetch_err=0, inst_valid=0.
REQ-034 imem_req_valid SHALL be 0 while rst=0 and assert on the first rising edge after release.
REQ-035 Reset asserted in any state (including S_WAIT with response pending) SHALL abandon the transaction; late responses are dropped per REQ-029.

Verification
REQ-036 Release reset, zero-wait memory returning 32'h00000413, inst_ready=1 -> req addr 0x80000000, inst_valid on cycle 3, next req addr 0x80000004, inst_cnt=1.
REQ-037 imem_req_ready held low 5 cycles -> imem_req_valid and addr stable for all 5 cycles, no state change.
REQ-038 In S_HOLD, inst_ready=0 for 4 cycles, then 1 with pc_wen=1, dnpc=0x80000100 -> inst stable 4 cycles, next req addr 0x80000100.
REQ-039 pc_wen=1, dnpc=0x80000102 at consume -> S_ERR, fetch_err=1, no further requests until reset.
REQ-040 imem_resp_err=1 in S_WAIT -> fetch_err=1, inst_valid never asserted; then rst=0 -> pc=0x80000000, fetch_err=0.
REQ-041 rst pulsed low mid-S_WAIT, stale imem_resp_valid arrives in S_REQ -> response ignored, fresh request to 0x80000000.
